// File: rtl/sdram_init_seq.sv
// sdram_init_seq
//   SDRAM power-up sequencer. After reset it waits out the power-up time, then
//   issues PRECHARGE-all, REF_NUM AUTO REFRESH commands, MRS and an optional
//   EMRS. Once in DONE it serves runtime mode-register rewrites over a
//   request/acknowledge handshake, and it restarts the full sequence on ReInit.
//   The main controller owns the command bus only while InitDone is 1.
//
// Ports
//   Clk            in   clock
//   Rest           in   synchronous active-high reset
//   ReInit         in   restart full sequence (honoured in DONE only)
//   MrsReq         in   runtime MRS request, level held until MrsAck
//   MrsVal         in   mode value for runtime MRS, latched on acceptance
//   MrsAck         out  one-cycle pulse when a runtime MRS completes
//   SdramCke       out  clock enable
//   SdramCmd       out  {CS_n,RAS_n,CAS_n,WE_n}
//   SdramAddr      out  A10 on PRE, mode value on MRS/EMRS, else 0
//   SdramBa        out  bank address, 2 on EMRS, else 0
//   InitBusy       out  1 while any sequence runs
//   InitDone       out  1 only in DONE
//   InitDonePulse  out  one-cycle pulse on DONE entry after a full init
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_STABLE     | power-up wait, issues PRE-all when the timer expires
// S_PRE_WAIT   | tRP after init PRE, then first REF
// S_REF_WAIT   | tRFC after a REF, then next REF or MRS
// S_MRS_WAIT   | tMRD after MRS, then EMRS (if enabled) or DONE
// S_EMRS_WAIT  | tMRD after EMRS, then DONE
// S_DONE       | initialised, bus handed to the main controller
// S_RPRE       | runtime rewrite accepted, issues PRE-all next
// S_RPRE_WAIT  | tRP after runtime PRE, then MRS with latched value
// S_RMRS_WAIT  | tMRD after runtime MRS, then DONE with MrsAck

module sdram_init_seq #(
    parameter int                CLK_MHZ     = 100,
    parameter int                ADDR_W      = 13,
    parameter int                BA_W        = 2,
    parameter int                T_STABLE_US = 200,
    parameter int                T_RP_NS     = 20,
    parameter int                T_RFC_NS    = 70,
    parameter int                T_MRD_CYC   = 2,
    parameter int                REF_NUM     = 8,
    parameter int                CAS_LAT     = 3,
    parameter logic [2:0]        BURST_LEN   = 3'b011,
    parameter logic              BURST_TYPE  = 1'b0,
    parameter int                EMRS_EN     = 0,
    parameter logic [ADDR_W-1:0] EMRS_VAL    = '0
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              ReInit,
    input  logic              MrsReq,
    input  logic [ADDR_W-1:0] MrsVal,
    output logic              MrsAck,
    output logic              SdramCke,
    output logic [3:0]        SdramCmd,
    output logic [ADDR_W-1:0] SdramAddr,
    output logic [BA_W-1:0]   SdramBa,
    output logic              InitBusy,
    output logic              InitDone,
    output logic              InitDonePulse
);

    localparam int T_STABLE_CYC = T_STABLE_US * CLK_MHZ;
    localparam int T_RP_RAW     = (T_RP_NS * CLK_MHZ + 999) / 1000;
    localparam int T_RFC_RAW    = (T_RFC_NS * CLK_MHZ + 999) / 1000;
    localparam int T_RP_CYC     = (T_RP_RAW < 1) ? 1 : T_RP_RAW;
    localparam int T_RFC_CYC    = (T_RFC_RAW < 1) ? 1 : T_RFC_RAW;
    localparam int MAX_A        = (T_STABLE_CYC > T_RFC_CYC) ? T_STABLE_CYC : T_RFC_CYC;
    localparam int MAX_B        = (T_RP_CYC > T_MRD_CYC) ? T_RP_CYC : T_MRD_CYC;
    localparam int MAX_CYC      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW           = $clog2(MAX_CYC + 1);
    localparam int RW           = $clog2(REF_NUM + 1);

    // The stable wait loads the full count because the expiry check happens
    // on the edge that issues PRE; every other wait loads count-1 because the
    // command edge itself already consumed one cycle.
    localparam logic [TW-1:0] LD_STABLE = TW'(T_STABLE_CYC);
    localparam logic [TW-1:0] LD_RP     = TW'(T_RP_CYC - 1);
    localparam logic [TW-1:0] LD_RFC    = TW'(T_RFC_CYC - 1);
    localparam logic [TW-1:0] LD_MRD    = TW'(T_MRD_CYC - 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [2:0]        CL_FIELD    = 3'(CAS_LAT);
    localparam logic [9:0]        MODE_FIELDS = {1'b0, 2'b00, CL_FIELD, BURST_TYPE, BURST_LEN};
    localparam logic [ADDR_W-1:0] MODE_DEF    = ADDR_W'(MODE_FIELDS);
    localparam logic [ADDR_W-1:0] ADDR_PRE    = ADDR_W'(1024);
    localparam logic [BA_W-1:0]   BA_EMRS     = BA_W'(2);
    localparam logic [RW-1:0]     REF_LAST    = RW'(REF_NUM);

    typedef enum logic [3:0] {
        S_STABLE,
        S_PRE_WAIT,
        S_REF_WAIT,
        S_MRS_WAIT,
        S_EMRS_WAIT,
        S_DONE,
        S_RPRE,
        S_RPRE_WAIT,
        S_RMRS_WAIT
    } state_t;

    state_t              state, state_nx;
    logic [TW-1:0]       timer, timer_nx;
    logic [RW-1:0]       ref_cnt, ref_nx;
    logic [ADDR_W-1:0]   mode_val, mode_nx;
    logic                cke_nx, busy_nx, done_nx, dpulse_nx, ack_nx;
    logic [3:0]          cmd_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [BA_W-1:0]     ba_nx;
    logic                tmr_zero;

    assign tmr_zero = (timer == '0);

    always_comb begin
        state_nx  = state;
        timer_nx  = tmr_zero ? timer : timer - TW'(1);
        ref_nx    = ref_cnt;
        mode_nx   = mode_val;
        cke_nx    = 1'b1;
        cmd_nx    = CMD_NOP;
        addr_nx   = '0;
        ba_nx     = '0;
        busy_nx   = 1'b1;
        done_nx   = 1'b0;
        dpulse_nx = 1'b0;
        ack_nx    = 1'b0;

        case (state)
            S_STABLE: begin
                if (tmr_zero) begin
                    cmd_nx   = CMD_PRE;
                    addr_nx  = ADDR_PRE;
                    timer_nx = LD_RP;
                    state_nx = S_PRE_WAIT;
                end
            end
            S_PRE_WAIT: begin
                if (tmr_zero) begin
                    cmd_nx   = CMD_REF;
                    timer_nx = LD_RFC;
                    ref_nx   = RW'(1);
                    state_nx = S_REF_WAIT;
                end
            end
            S_REF_WAIT: begin
                if (tmr_zero) begin
                    if (ref_cnt < REF_LAST) begin
                        cmd_nx   = CMD_REF;
                        timer_nx = LD_RFC;
                        ref_nx   = ref_cnt + RW'(1);
                    end else begin
                        cmd_nx   = CMD_MRS;
                        addr_nx  = mode_val;
                        timer_nx = LD_MRD;
                        state_nx = S_MRS_WAIT;
                    end
                end
            end
            S_MRS_WAIT: begin
                if (tmr_zero) begin
                    if (EMRS_EN != 0) begin
                        cmd_nx   = CMD_MRS;
                        addr_nx  = EMRS_VAL;
                        ba_nx    = BA_EMRS;
                        timer_nx = LD_MRD;
                        state_nx = S_EMRS_WAIT;
                    end else begin
                        busy_nx   = 1'b0;
                        done_nx   = 1'b1;
                        dpulse_nx = 1'b1;
                        state_nx  = S_DONE;
                    end
                end
            end
            S_EMRS_WAIT: begin
                if (tmr_zero) begin
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                    dpulse_nx = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            S_DONE: begin
                busy_nx = 1'b0;
                done_nx = 1'b1;
                // ReInit outranks a pending MrsReq; the request stays pending
                // and is picked up on the first DONE cycle after re-init.
                if (ReInit) begin
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    timer_nx = LD_STABLE;
                    ref_nx   = '0;
                    state_nx = S_STABLE;
                end else if (MrsReq) begin
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    mode_nx  = MrsVal;
                    state_nx = S_RPRE;
                end
            end
            S_RPRE: begin
                cmd_nx   = CMD_PRE;
                addr_nx  = ADDR_PRE;
                timer_nx = LD_RP;
                state_nx = S_RPRE_WAIT;
            end
            S_RPRE_WAIT: begin
                if (tmr_zero) begin
                    cmd_nx   = CMD_MRS;
                    addr_nx  = mode_val;
                    timer_nx = LD_MRD;
                    state_nx = S_RMRS_WAIT;
                end
            end
            S_RMRS_WAIT: begin
                if (tmr_zero) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    ack_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            default: begin
                timer_nx = LD_STABLE;
                ref_nx   = '0;
                state_nx = S_STABLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state         <= S_STABLE;
            timer         <= LD_STABLE;
            ref_cnt       <= '0;
            mode_val      <= MODE_DEF;
            SdramCke      <= 1'b0;
            SdramCmd      <= CMD_NOP;
            SdramAddr     <= '0;
            SdramBa       <= '0;
            InitBusy      <= 1'b1;
            InitDone      <= 1'b0;
            InitDonePulse <= 1'b0;
            MrsAck        <= 1'b0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            ref_cnt       <= ref_nx;
            mode_val      <= mode_nx;
            SdramCke      <= cke_nx;
            SdramCmd      <= cmd_nx;
            SdramAddr     <= addr_nx;
            SdramBa       <= ba_nx;
            InitBusy      <= busy_nx;
            InitDone      <= done_nx;
            InitDonePulse <= dpulse_nx;
            MrsAck        <= ack_nx;
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq
//   Scoreboard bench for sdram_init_seq. Drivers push the expected command /
//   pulse timeline into per-DUT queues; a monitor pops an entry every cycle a
//   DUT shows a command or pulse and compares cycle number and fields.
//   dut0 runs without EMRS and sees randomized runtime traffic; dut1 runs with
//   EMRS enabled.

module tb_sdram_init_seq;

    localparam int CLK_MHZ     = 100;
    localparam int T_STABLE_US = 1;
    localparam int T_RP_NS     = 20;
    localparam int T_RFC_NS    = 70;
    localparam int T_MRD_CYC   = 2;
    localparam int REF_NUM     = 2;
    localparam int CAS_LAT     = 3;
    localparam logic [12:0] EMRS_VAL = 13'h040;

    // reference timing, straight from the datasheet-style formulas
    localparam int TS   = T_STABLE_US * CLK_MHZ;
    localparam int TRP  = ((T_RP_NS * CLK_MHZ + 999) / 1000 < 1) ? 1 : (T_RP_NS * CLK_MHZ + 999) / 1000;
    localparam int TRFC = ((T_RFC_NS * CLK_MHZ + 999) / 1000 < 1) ? 1 : (T_RFC_NS * CLK_MHZ + 999) / 1000;
    localparam int TMRD = T_MRD_CYC;
    localparam int SEQ_LEN = TS + TRP + REF_NUM * TRFC + TMRD;

    localparam logic [12:0] MODE_DEF = 13'((CAS_LAT << 4) | (0 << 3) | 3);
    localparam logic [3:0]  C_NOP = 4'b0111;
    localparam logic [3:0]  C_PRE = 4'b0010;
    localparam logic [3:0]  C_REF = 4'b0001;
    localparam logic [3:0]  C_MRS = 4'b0000;
    localparam logic [23:0] RST_VEC = {1'b0, 4'b0111, 13'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};

    logic        Clk;
    logic        Rest0, ReInit0, MrsReq0;
    logic [12:0] MrsVal0;
    logic        ack0, cke0, busy0, done0, dp0;
    logic [3:0]  cmd0;
    logic [12:0] addr0;
    logic [1:0]  ba0;
    logic        Rest1, ReInit1, MrsReq1;
    logic [12:0] MrsVal1;
    logic        ack1, cke1, busy1, done1, dp1;
    logic [3:0]  cmd1;
    logic [12:0] addr1;
    logic [1:0]  ba1;

    sdram_init_seq #(
        .CLK_MHZ(CLK_MHZ), .ADDR_W(13), .BA_W(2), .T_STABLE_US(T_STABLE_US),
        .T_RP_NS(T_RP_NS), .T_RFC_NS(T_RFC_NS), .T_MRD_CYC(T_MRD_CYC),
        .REF_NUM(REF_NUM), .CAS_LAT(CAS_LAT), .BURST_LEN(3'b011),
        .BURST_TYPE(1'b0), .EMRS_EN(0), .EMRS_VAL(13'h0)
    ) u_dut0 (
        .Clk(Clk), .Rest(Rest0), .ReInit(ReInit0), .MrsReq(MrsReq0), .MrsVal(MrsVal0),
        .MrsAck(ack0), .SdramCke(cke0), .SdramCmd(cmd0), .SdramAddr(addr0),
        .SdramBa(ba0), .InitBusy(busy0), .InitDone(done0), .InitDonePulse(dp0)
    );

    sdram_init_seq #(
        .CLK_MHZ(CLK_MHZ), .ADDR_W(13), .BA_W(2), .T_STABLE_US(T_STABLE_US),
        .T_RP_NS(T_RP_NS), .T_RFC_NS(T_RFC_NS), .T_MRD_CYC(T_MRD_CYC),
        .REF_NUM(REF_NUM), .CAS_LAT(CAS_LAT), .BURST_LEN(3'b011),
        .BURST_TYPE(1'b0), .EMRS_EN(1), .EMRS_VAL(EMRS_VAL)
    ) u_dut1 (
        .Clk(Clk), .Rest(Rest1), .ReInit(ReInit1), .MrsReq(MrsReq1), .MrsVal(MrsVal1),
        .MrsAck(ack1), .SdramCke(cke1), .SdramCmd(cmd1), .SdramAddr(addr1),
        .SdramBa(ba1), .InitBusy(busy1), .InitDone(done1), .InitDonePulse(dp1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int edge_cnt = 0;
    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [12:0] addr;
        logic [1:0] ba;
        logic       dp;
        logic       ack;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en0 = 1'b0;
    bit  mon_en1 = 1'b0;

    function automatic void push_ev(int idx, int c, logic [3:0] cmd, logic [12:0] addr,
                                    logic [1:0] ba, logic dp, logic ack);
        ev_t e;
        e.cyc = c; e.cmd = cmd; e.addr = addr; e.ba = ba; e.dp = dp; e.ack = ack;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endfunction

    // full init whose cycle 0 is 'base'; returns the DONE entry cycle
    function automatic int push_init(int idx, int base, logic [12:0] mode, bit emrs);
        int t;
        t = base + TS;
        push_ev(idx, t, C_PRE, 13'h400, 2'd0, 1'b0, 1'b0);
        t = t + TRP;
        for (int k = 0; k < REF_NUM; k++) begin
            push_ev(idx, t, C_REF, 13'h0, 2'd0, 1'b0, 1'b0);
            t = t + TRFC;
        end
        push_ev(idx, t, C_MRS, mode, 2'd0, 1'b0, 1'b0);
        t = t + TMRD;
        if (emrs) begin
            push_ev(idx, t, C_MRS, EMRS_VAL, 2'd2, 1'b0, 1'b0);
            t = t + TMRD;
        end
        push_ev(idx, t, C_NOP, 13'h0, 2'd0, 1'b1, 1'b0);
        return t;
    endfunction

    // runtime rewrite accepted on edge 'a'; returns the MrsAck cycle
    function automatic int push_rmrs(int idx, int a, logic [12:0] val);
        int t;
        t = a + 1;
        push_ev(idx, t, C_PRE, 13'h400, 2'd0, 1'b0, 1'b0);
        t = t + TRP;
        push_ev(idx, t, C_MRS, val, 2'd0, 1'b0, 1'b0);
        t = t + TMRD;
        push_ev(idx, t, C_NOP, 13'h0, 2'd0, 1'b0, 1'b1);
        return t;
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d (0x%0h) required %0d (0x%0h)",
                     name, edge_cnt, got, got, exp, exp);
        end
    endtask

    task automatic mon_one(int idx, logic [3:0] cmd, logic [12:0] addr, logic [1:0] ba,
                           logic dp, logic ack);
        ev_t e;
        bit  empty;
        if (cmd == C_NOP && !dp && !ack) return;
        checks++;
        empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            errors++;
            $display("FAIL unexpected_event dut%0d got cyc=%0d cmd=%b addr=%h ba=%0d dp=%0b ack=%0b required none",
                     idx, edge_cnt, cmd, addr, ba, dp, ack);
            return;
        end
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        if (e.cyc != edge_cnt || e.cmd != cmd || e.addr != addr || e.ba != ba ||
            e.dp != dp || e.ack != ack) begin
            errors++;
            $display("FAIL event dut%0d got cyc=%0d cmd=%b addr=%h ba=%0d dp=%0b ack=%0b required cyc=%0d cmd=%b addr=%h ba=%0d dp=%0b ack=%0b",
                     idx, edge_cnt, cmd, addr, ba, dp, ack, e.cyc, e.cmd, e.addr, e.ba, e.dp, e.ack);
        end
    endtask

    always begin
        @(posedge Clk);
        #1;
        if (mon_en0) mon_one(0, cmd0, addr0, ba0, dp0, ack0);
        if (mon_en1) mon_one(1, cmd1, addr1, ba1, dp1, ack1);
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic wait_done(int idx, int exp_cyc, string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            seen = (idx == 0) ? done0 : done1;
        end
        chk({name, "_seen"}, int'(seen), 1);
        if (seen) begin
            chk({name, "_cycle"}, edge_cnt, exp_cyc);
            chk({name, "_busy"}, (idx == 0) ? int'(busy0) : int'(busy1), 0);
        end
    endtask

    task automatic wait_ack(int idx, int exp_cyc, string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            seen = (idx == 0) ? ack0 : ack1;
        end
        chk({name, "_seen"}, int'(seen), 1);
        if (seen) begin
            chk({name, "_cycle"}, edge_cnt, exp_cyc);
            chk({name, "_done"}, (idx == 0) ? int'(done0) : int'(done1), 1);
        end
    endtask

    logic [12:0] mode_m;

    task automatic do_mrs0(logic [12:0] val);
        int a, ac;
        MrsVal0 = val;
        MrsReq0 = 1'b1;
        a  = edge_cnt + 1;
        ac = push_rmrs(0, a, val);
        mode_m = val;
        step();
        chk("rmrs_accept_done_busy", int'({done0, busy0}), 1);
        wait_ack(0, ac, "rmrs_ack");
        MrsReq0 = 1'b0;
    endtask

    task automatic do_reinit0();
        int a, d;
        ReInit0 = 1'b1;
        a = edge_cnt + 1;
        d = push_init(0, a + 1, mode_m, 1'b0);
        step();
        ReInit0 = 1'b0;
        chk("reinit_accept_done_busy_cke", int'({done0, busy0, cke0}), 3);
        wait_done(0, d, "reinit_done");
    endtask

    task automatic do_both0(logic [12:0] val);
        int a, d, ac;
        MrsVal0 = val;
        ReInit0 = 1'b1;
        MrsReq0 = 1'b1;
        a  = edge_cnt + 1;
        d  = push_init(0, a + 1, mode_m, 1'b0);
        ac = push_rmrs(0, d + 1, val);
        step();
        ReInit0 = 1'b0;
        chk("both_accept_done", int'(done0), 0);
        wait_done(0, d, "both_init_done");
        wait_ack(0, ac, "both_ack");
        MrsReq0 = 1'b0;
        mode_m = val;
    endtask

    // start a re-init, then hit Rest so the reset edge lands at cycle 'off'
    task automatic do_rest0(int off);
        int a, base, d;
        ReInit0 = 1'b1;
        a = edge_cnt + 1;
        d = push_init(0, a + 1, mode_m, 1'b0);
        step();
        ReInit0 = 1'b0;
        base = a + 1;
        for (int i = 0; i < 400 && edge_cnt < base + off - 1; i++) step();
        Rest0 = 1'b1;
        q0.delete();
        step();
        chk("rest_mid_reset_vals", int'({cke0, cmd0, addr0, ba0, busy0, done0, dp0, ack0}), int'(RST_VEC));
        Rest0 = 1'b0;
        mode_m = MODE_DEF;
        base = edge_cnt + 1;
        d = push_init(0, base, mode_m, 1'b0);
        step();
        chk("rest_restart_cke", int'(cke0), 1);
        wait_done(0, d, "rest_restart_done");
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout at edge %0d: got no finish required finish", edge_cnt);
        $fatal(1, "global timeout");
    end

    initial begin
        Rest0 = 1'b1; ReInit0 = 1'b0; MrsReq0 = 1'b0; MrsVal0 = 13'h0;
        Rest1 = 1'b1; ReInit1 = 1'b0; MrsReq1 = 1'b0; MrsVal1 = 13'h0;
        mode_m = MODE_DEF;
        fork
            begin : drv0
                int base, d, r, op;
                logic [12:0] v;
                repeat (3) step();
                chk("reset_vals_dut0", int'({cke0, cmd0, addr0, ba0, busy0, done0, dp0, ack0}), int'(RST_VEC));
                mon_en0 = 1'b1;
                Rest0 = 1'b0;
                base = edge_cnt + 1;
                d = push_init(0, base, MODE_DEF, 1'b0);
                step();
                chk("cycle0_cke_busy_done", int'({cke0, busy0, done0}), 6);
                // requests mid-sequence must be ignored
                r = $urandom_range(5, 110);
                for (int i = 0; i < 400 && edge_cnt < base + r; i++) step();
                ReInit0 = 1'b1;
                MrsReq0 = 1'b1;
                MrsVal0 = 13'($urandom);
                step();
                ReInit0 = 1'b0;
                MrsReq0 = 1'b0;
                wait_done(0, d, "init_done");
                do_mrs0(13'h023);
                do_rest0(105);
                do_both0(13'($urandom));
                for (int n = 0; n < 10; n++) begin
                    repeat ($urandom_range(0, 4)) step();
                    op = $urandom_range(0, 3);
                    v  = 13'($urandom);
                    case (op)
                        0: do_mrs0(v);
                        1: do_reinit0();
                        2: do_both0(v);
                        default: do_rest0($urandom_range(1, SEQ_LEN - 1));
                    endcase
                end
                repeat (5) step();
            end
            begin : drv1
                int b1, d1, a1, ac1;
                logic [12:0] v1;
                repeat (3) step();
                chk("reset_vals_dut1", int'({cke1, cmd1, addr1, ba1, busy1, done1, dp1, ack1}), int'(RST_VEC));
                mon_en1 = 1'b1;
                Rest1 = 1'b0;
                b1 = edge_cnt + 1;
                d1 = push_init(1, b1, MODE_DEF, 1'b1);
                wait_done(1, d1, "emrs_init_done");
                v1 = 13'($urandom);
                MrsVal1 = v1;
                MrsReq1 = 1'b1;
                a1  = edge_cnt + 1;
                ac1 = push_rmrs(1, a1, v1);
                wait_ack(1, ac1, "emrs_rmrs_ack");
                MrsReq1 = 1'b0;
                ReInit1 = 1'b1;
                a1 = edge_cnt + 1;
                d1 = push_init(1, a1 + 1, v1, 1'b1);
                step();
                ReInit1 = 1'b0;
                wait_done(1, d1, "emrs_reinit_done");
                repeat (5) step();
            end
        join
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
